clk_gate_ctrl: RTL and testbench

//  Sequences one integrated clock-gating cell (ICG) that feeds a shared, clock-gated resource (e.g. ALU).

---
 rtl/clk_gate_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate sequencer for one shared, clock-gated resource, with a round-robin grant among NUM_REQ requesters.
// It wakes the ICG on demand, waits WAKE_CYCLES for the gated domain to settle, and gates the clock off after an idle timeout.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic                       FORCE_ON,
  output logic                       GATE_EN,
  output logic [NUM_REQ-1:0]         GNT,
  output logic [$clog2(NUM_REQ)-1:0] GNT_ID,
  output logic                       BUSY
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int ICNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAKE_CYCLES - 1);
  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(IDLE_CYCLES - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_WAKE,
    ST_ARB,
    ST_BUSY
  } state_t;

  state_t              state_q, state_d;
  logic                gate_en_q, gate_en_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [ICNT_W-1:0]   icnt_q, icnt_d;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     rr_next;

  // Search starts at the rr pointer and wraps, so the most recent owner is considered last.
  always_comb begin
    pick_valid  = 1'b0;
    pick_id     = '0;
    pick_onehot = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (!pick_valid && REQ[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
    pick_onehot[pick_id] = pick_valid;
  end

  assign rr_next = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    gate_en_d = gate_en_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    rr_d      = rr_q;
    wcnt_d    = wcnt_q;
    icnt_d    = icnt_q;

    case (state_q)
      ST_OFF: begin
        gate_en_d = 1'b0;
        if (|REQ || FORCE_ON) begin
          state_d   = ST_WAKE;
          gate_en_d = 1'b1;
          wcnt_d    = WCNT_INIT;
        end
      end

      ST_WAKE: begin
        if (wcnt_q == '0) begin
          state_d = ST_ARB;
          icnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end

      ST_ARB: begin
        if (pick_valid) begin
          state_d  = ST_BUSY;
          gnt_d    = pick_onehot;
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
        end else if (FORCE_ON) begin
          icnt_d = '0;
        end else if (icnt_q == ICNT_LAST) begin
          state_d   = ST_OFF;
          gate_en_d = 1'b0;
        end else begin
          icnt_d = icnt_q + ICNT_W'(1);
        end
      end

      ST_BUSY: begin
        // Non-preemptive: only the owner's own request line matters here.
        if (!REQ[gnt_id_q]) begin
          state_d  = ST_ARB;
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
          rr_d     = rr_next;
          icnt_d   = '0;
        end
      end

      default: begin
        state_d   = ST_OFF;
        gate_en_d = 1'b0;
        gnt_d     = '0;
        gnt_id_d  = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_OFF;
      gate_en_q <= 1'b0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      rr_q      <= '0;
      wcnt_q    <= '0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      rr_q      <= rr_d;
      wcnt_q    <= wcnt_d;
      icnt_q    <= icnt_d;
    end
  end

  assign GATE_EN = gate_en_q;
  assign GNT     = gnt_q;
  assign GNT_ID  = gnt_id_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (NUM_REQ=2, WAKE_CYCLES=2, IDLE_CYCLES=4).
// Expected values are hand-derived per scenario; outputs are sampled 1ns after each rising edge.
module tb_clk_gate_ctrl;

  localparam int NUM_REQ     = 2;
  localparam int WAKE_CYCLES = 2;
  localparam int IDLE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       force_on;
  logic       gate_en;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .WAKE_CYCLES(WAKE_CYCLES),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .REQ     (req),
    .FORCE_ON(force_on),
    .GATE_EN (gate_en),
    .GNT     (gnt),
    .GNT_ID  (gnt_id),
    .BUSY    (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic expectState(input string tag, input logic ge, input logic [1:0] g, input logic gid, input logic b);
    checkOutput({tag, ".gate_en"}, {31'b0, gate_en}, {31'b0, ge});
    checkOutput({tag, ".gnt"},     {30'b0, gnt},     {30'b0, g});
    checkOutput({tag, ".gnt_id"},  {31'b0, gnt_id},  {31'b0, gid});
    checkOutput({tag, ".busy"},    {31'b0, busy},    {31'b0, b});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic f);
    req      = r;
    force_on = f;
  endtask

  // Each idle ARB cycle keeps the gate open until the IDLE_CYCLES-th one ends.
  task automatic expectIdleTimeout(input string tag);
    for (int k = 0; k < IDLE_CYCLES - 1; k++) begin
      tick;
      expectState({tag, "_idle"}, 1'b1, 2'b00, 1'b0, 1'b0);
    end
    tick;
    expectState({tag, "_off"}, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  logic       owner;
  logic [1:0] drop;

  initial begin
    // Scenario 1: reset held with both requests high, then wake and first grant.
    rst_n = 1'b0;
    applyStimulus(2'b11, 1'b0);
    #1;
    expectState("t1_rst0", 1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick;
      expectState("t1_rst", 1'b0, 2'b00, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    tick;
    expectState("t1_wake1", 1'b1, 2'b00, 1'b0, 1'b0);
    tick;
    expectState("t1_wake2", 1'b1, 2'b00, 1'b0, 1'b0);
    tick;
    expectState("t1_arb", 1'b1, 2'b00, 1'b0, 1'b0);
    tick;
    expectState("t1_gnt", 1'b1, 2'b01, 1'b0, 1'b1);

    // Scenario 2: owner 0 releases while requester 1 waits.
    applyStimulus(2'b10, 1'b0);
    tick;
    expectState("t2_bubble", 1'b1, 2'b00, 1'b0, 1'b0);
    tick;
    expectState("t2_gnt", 1'b1, 2'b10, 1'b1, 1'b1);

    // Scenario 3: both requesting, owners release in turn; grants alternate.
    applyStimulus(2'b11, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick;
      expectState("t3_hold0", 1'b1, 2'b10, 1'b1, 1'b1);
    end
    owner = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drop = 2'b11;
      drop[owner] = 1'b0;
      applyStimulus(drop, 1'b0);
      tick;
      expectState("t3_bubble", 1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b11, 1'b0);
      owner = ~owner;
      for (int k = 0; k < 3; k++) begin
        tick;
        expectState("t3_owner", 1'b1, owner ? 2'b10 : 2'b01, owner, 1'b1);
      end
    end

    // Scenario 4a: owner 0 releases, nothing requested; idle timeout.
    applyStimulus(2'b00, 1'b0);
    tick;
    expectState("t4_rel", 1'b1, 2'b00, 1'b0, 1'b0);
    expectIdleTimeout("t4a");

    // Scenario 4b: rr=1 but only requester 0 asks, so the search wraps.
    applyStimulus(2'b01, 1'b0);
    for (int k = 0; k < WAKE_CYCLES + 1; k++) begin
      tick;
      expectState("t4b_wake", 1'b1, 2'b00, 1'b0, 1'b0);
    end
    tick;
    expectState("t4b_gnt", 1'b1, 2'b01, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0);
    tick;
    expectState("t4b_rel", 1'b1, 2'b00, 1'b0, 1'b0);
    tick;
    tick;
    expectState("t4b_idle2", 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0);
    tick;
    expectState("t4b_pulse_gnt", 1'b1, 2'b10, 1'b1, 1'b1);
    applyStimulus(2'b00, 1'b0);
    tick;
    expectState("t4b_pulse_rel", 1'b1, 2'b00, 1'b0, 1'b0);
    expectIdleTimeout("t4b");

    // Scenario 5: FORCE_ON alone keeps the clock running with no grant.
    applyStimulus(2'b00, 1'b1);
    tick;
    expectState("t5_wake", 1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick;
      expectState("t5_forced", 1'b1, 2'b00, 1'b0, 1'b0);
    end
    applyStimulus(2'b00, 1'b0);
    expectIdleTimeout("t5");

    // Scenario 6: move rr to 1, then reset asynchronously while owner 1 is busy.
    applyStimulus(2'b01, 1'b0);
    for (int k = 0; k < WAKE_CYCLES + 2; k++) tick;
    expectState("t6_gnt0", 1'b1, 2'b01, 1'b0, 1'b1);
    applyStimulus(2'b10, 1'b0);
    tick;
    tick;
    expectState("t6_gnt1", 1'b1, 2'b10, 1'b1, 1'b1);
    applyStimulus(2'b11, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    expectState("t6_async_rst", 1'b0, 2'b00, 1'b0, 1'b0);
    tick;
    expectState("t6_rst_hold", 1'b0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < WAKE_CYCLES + 1; k++) begin
      tick;
      expectState("t6_wake", 1'b1, 2'b00, 1'b0, 1'b0);
    end
    tick;
    expectState("t6_rr_reset", 1'b1, 2'b01, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
